// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage divide sequencer: FSM states, iteration count and stall levels.
package ex_div_ctrl_pkg;

  localparam int DIV_CYCLES = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_ZERO = 2'd1;
  localparam logic [1:0] DIV_RUN  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One combinational restoring-division iteration on magnitudes; caller keeps rem < dvs between steps.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              ge;

  assign rem_sh = {rem_i, quo_i[DATA_W-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_i});
  // When ge holds the true difference is below dvs, so the low bits carry it exactly.
  assign diff   = rem_sh[DATA_W-1:0] - dvs_i;
  assign rem_o  = ge ? diff : rem_sh[DATA_W-1:0];
  assign quo_o  = {quo_i[DATA_W-2:0], ge};

endmodule

// File: rtl/ex_div_ctrl.sv
// DIV/DIVU sequencer for EX: 32-cycle restoring divide with stall request and sign fix-up.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic              annul_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] res_quo_q, res_quo_d;
  logic [DATA_W-1:0] res_rem_q, res_rem_d;

  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] fix_quo, fix_rem;

  assign dvd_neg = signed_div_i & dividend_i[DATA_W-1];
  assign dvs_neg = signed_div_i & divisor_i[DATA_W-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign fix_quo = neg_quo_q ? -step_quo : step_quo;
  assign fix_rem = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          dvd_d     = dividend_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          rem_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          cnt_d     = '0;
          res_quo_d = '0;
          res_rem_d = '0;
          if (divisor_i == '0) begin
            state_d = DIV_ZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (dvd_mag < dvs_mag) begin
            state_d   = DIV_DONE;
            res_rem_d = dividend_i;
          end
`endif
          else begin
            state_d = DIV_RUN;
          end
        end
      end
      DIV_ZERO: begin
        if (start_i) begin
          state_d   = DIV_DONE;
          res_quo_d = '1;
          res_rem_d = dvd_q;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (start_i) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d   = DIV_DONE;
            res_quo_d = fix_quo;
            res_rem_d = fix_rem;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_DONE: begin
        if (!start_i) begin
          state_d   = DIV_IDLE;
          res_quo_d = '0;
          res_rem_d = '0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    // A flush wins over every other transition and leaves no stale result visible.
    if (annul_i) begin
      state_d   = DIV_IDLE;
      res_quo_d = '0;
      res_rem_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
    end
  end

  assign stall_req_o    = (start_i && !annul_i && (state_q != DIV_DONE)) ? STALL_ENABLE : STALL_DISABLE;
  assign busy_o         = (state_q != DIV_IDLE);
  assign result_valid_o = (state_q == DIV_DONE);
  assign quotient_o     = res_quo_q;
  assign remainder_o    = res_rem_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomized and directed bench for ex_div_ctrl against an arithmetic reference model.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, sgn, annul;
  logic [31:0] dvd, dvs;
  logic        stall, busy, valid;
  logic [31:0] quo, rem;

  int vectors = 0;
  int fails   = 0;

  logic        chk_en    = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_zero  = 1'b0;
  logic [31:0] exp_q     = '0;
  logic [31:0] exp_r     = '0;

  ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .signed_div_i   (sgn),
    .annul_i        (annul),
    .dividend_i     (dvd),
    .divisor_i      (dvs),
    .stall_req_o    (stall),
    .busy_o         (busy),
    .result_valid_o (valid),
    .quotient_o     (quo),
    .remainder_o    (rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, expv);
    end
  endtask

  // Outputs are sampled on the falling edge, well clear of the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_req", {31'd0, stall}, {31'd0, start & ~annul & ~exp_valid});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("result_valid", {31'd0, valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("quotient", quo, exp_q);
        chk("remainder", rem, exp_r);
      end
      if (exp_zero) begin
        chk("quotient_clear", quo, 32'd0);
        chk("remainder_clear", rem, 32'd0);
      end
    end
  end

  // Truncating division on 64-bit integers sidesteps the -2^31 / -1 overflow.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    longint la, lb, lq, lr;
    logic [31:0] ma, mb;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 2;
    end else begin
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      lq  = la / lb;
      lr  = la % lb;
      q   = lq[31:0];
      r   = lr[31:0];
      lat = 33;
      ma  = (s && a[31]) ? (32'd0 - a) : a;
      mb  = (s && b[31]) ? (32'd0 - b) : b;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`else
      if (ma < mb) lat = 33;
`endif
    end
  endtask

  // kind: 0 none, 1 annul pulse, 2 start dropped, 3 reset; applied at cycle 'at' after start.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int kind, input int at,
                     input logic use_lit, input logic [31:0] lq, input logic [31:0] lr);
    logic [31:0] mq, mr;
    int lat;
    model(a, b, s, mq, mr, lat);
    if (use_lit && kind == 0) begin
      chk("model_pin_q", mq, lq);
      chk("model_pin_r", mr, lr);
    end
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b0; sgn = s; dvd = a; dvs = b;
    exp_busy = 1'b0; exp_valid = 1'b0;
    exp_q = use_lit ? lq : mq;
    exp_r = use_lit ? lr : mr;
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      exp_zero = 1'b0;
      exp_busy = 1'b1;
      dvd = $urandom;
      dvs = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (kind != 0 && k == at) begin
        case (kind)
          1: annul = 1'b1;
          2: start = 1'b0;
          default: begin rst = 1'b1; start = 1'b0; end
        endcase
        @(posedge clk); #1;
        annul = 1'b0; rst = 1'b0; start = 1'b0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_zero = 1'b1;
        return;
      end
      exp_valid = (k >= lat);
      if (k == lat + 2) start = 1'b0;
    end
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; dvd = '0; dvs = '0;
    @(posedge clk); #1;
    exp_zero = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0, 0, 0, 1'b1, 32'd14, 32'd2);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b1, 32'h8000_0000, 32'd0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    run(32'd5, 32'd0, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'd5);
    run(32'hFFFF_FFF9, 32'd0, 1'b1, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run(32'd100, 32'd7, 1'b0, 1, 10, 1'b0, 32'd0, 32'd0);
    run(32'd100, 32'd7, 1'b0, 2, 15, 1'b0, 32'd0, 32'd0);
    run(32'd100, 32'd7, 1'b0, 3, 20, 1'b0, 32'd0, 32'd0);
    run(32'd9, 32'd3, 1'b0, 0, 0, 1'b1, 32'd3, 32'd0);
    run(32'd3, 32'd10, 1'b0, 0, 0, 1'b1, 32'd0, 32'd3);
    run(32'hFFFF_FFFD, 32'd10, 1'b1, 0, 0, 1'b1, 32'd0, 32'hFFFF_FFFD);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin rb = $urandom; ra = 32'($urandom_range(0, 50)); end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      run(ra, rb, rs, 0, 0, 1'b0, 32'd0, 32'd0);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
